aes128_mix_columns_par: RTL and testbench
=========================================

Name: aes128_mix_columns_par

Overview:
- Parametrised successor to the serial MixColumns unit: performs AES MixColumns (ENCRYPT) or InvMixColumns (DECRYPT) on a 128-bit state.
- LANES parallel GF(2^8) constant multipliers trade area against latency.
- Output is one byte per beat on a ready/valid stream with byte address, so downstream byte-wide state storage can apply backpressure.
- Sits between ShiftRows and AddRoundKey in the round datapath.

Parameters:
- LANES, 1: GF products computed per cycle. Legal values 1, 2, 4; any other value is an elaboration error.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start request; sampled only in IDLE
- mode_i  in  mode_t  ENCRYPT/DECRYPT (aes128_type_pkg); sampled with start_i
- data_i  in  128  state; column c = data_i[c*32+:32], row r of column = bits [r*8+:8]
- ready_i  in  1  downstream ready for current byte
- valid_o  out  1  data_o/addr_o valid
- data_o  out  8  result byte
- addr_o  out  4  byte address = c*4 + r
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse after the last byte handshake

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; valid_o=0, data_o=0, addr_o=0, busy_o=0, done_o=0; counters and accumulator cleared. Reset mid-operation abandons the block with no done_o.
- States: IDLE, CALC, OUT, DONE.
- IDLE: on start_i=1, latch data_i and mode_i, clear byte index (c=0, r=0), then go to CALC. start_i is ignored in all other states.
- Coefficients for output byte (c,r): product k (k=0..3) = in[c][k] • M[(k-r) mod 4].
  - ENCRYPT: M = {2,3,1,1}.
  - DECRYPT: M = {14,11,13,9}.
- GF multiply: reduction polynomial 0x11B. Lane products are combinational (xtime chains). Accumulation is XOR, never integer add.
- CALC lasts 4/LANES cycles. Each cycle XORs LANES products into the accumulator. The accumulator is loaded, not XORed, on the first CALC cycle of each byte. On the last CALC cycle, go to OUT.
- OUT: valid_o=1, data_o=accumulator, addr_o=c*4+r. These are held stable while ready_i=0.
  - On valid_o&&ready_i with byte index <15: increment index (r fastest, then c) and go to CALC.
  - On valid_o&&ready_i with byte index 15: go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. valid_o=0 in DONE.
- Timing, start accepted at cycle T and ready_i held 1:
  - Byte n is valid at T + (n+1)*(4/LANES+1).
  - LANES=1: first valid T+5, last valid T+80, done_o T+81.
  - LANES=2: last valid T+48, done_o T+49.
  - LANES=4: last valid T+32, done_o T+33.
- Output order is strictly addr 0..15.
- Latched mode/data are unaffected by input changes after start.

Optional Feature:
- Macro AES128_MC_ABORT_EN.
- Defined:
  - Adds input port abort_i (1 bit), placed after ready_i.
  - abort_i=1 in any non-IDLE state returns to IDLE on the next edge, with valid_o=0 and no done_o pulse.
  - abort_i has priority over a simultaneous handshake. abort_i is ignored in IDLE.
  - A start_i in the same cycle as abort_i in IDLE is accepted normally.
- Undefined: no abort_i port; an operation can only be terminated by reset.

Test Plan:
- ENCRYPT, LANES=1, ready_i=1, column 0 bytes r0..r3 = db,13,53,45, other columns c6 c6 c6 c6 -> addr0..3 = 8e,4d,a1,bc; addr4..15 = c6; first valid at T+5, done_o pulse at T+81 only.
- DECRYPT, LANES=4, column 0 = 8e,4d,a1,bc, column 1 = 9f,dc,58,9d -> addr0..3 = db,13,53,45; addr4..7 = f2,0a,22,5c; done_o at T+33.
- ENCRYPT, LANES=2, column d4,bf,5d,30 -> 04,66,81,e5; other columns 01 01 01 01 -> 01; done_o at T+49.
- Backpressure: ready_i=0 for 7 cycles on addr 5 -> valid_o/data_o/addr_o held constant; no byte skipped or duplicated; done_o delayed by exactly 7 cycles.
- start_i pulsed while busy_o=1, and mode_i/data_i changed mid-run -> ignored; outputs match the originally latched inputs.
- rst_n_i asserted asynchronously mid-CALC -> all outputs 0 immediately, without waiting for a clock edge. Next start produces a full correct 16-byte run.
- (AES128_MC_ABORT_EN) abort_i at addr 9 with ready_i=1 -> IDLE next cycle, no byte 9 handshake, no done_o; next start completes normally.

Source files
------------

// File: rtl/aes128_mix_columns_par.sv
`default_nettype none
// ============================================================================
// Module   : aes128_mix_columns_par
// Brief    : AES (Inv)MixColumns with LANES parallel GF(2^8) multipliers and
//            a byte-wide ready/valid output. Optional abort_i port under the
//            macro AES128_MC_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================

package aes128_type_pkg;
    typedef enum logic {ENCRYPT = 1'b0, DECRYPT = 1'b1} mode_t;
endpackage

module aes128_mix_columns_par
    import aes128_type_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  mode_t        mode_i,
    input  logic [127:0] data_i,
    input  logic         ready_i,
`ifdef AES128_MC_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         valid_o,
    output logic [7:0]   data_o,
    output logic [3:0]   addr_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int         c_beats = 4 / LANES;
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_calc  = 2'd1;
    localparam logic [1:0] c_out   = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("aes128_mix_columns_par: LANES must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant coefficients never exceed 4 bits, so three xtime steps suffice.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2;
        logic [7:0] a4;
        logic [7:0] a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
    endfunction

    function automatic logic [3:0] coef(input mode_t m, input logic [1:0] j);
        logic [3:0] c;
        if (m == DECRYPT) begin
            case (j)
                2'd0:    c = 4'd14;
                2'd1:    c = 4'd11;
                2'd2:    c = 4'd13;
                default: c = 4'd9;
            endcase
        end else begin
            case (j)
                2'd0:    c = 4'd2;
                2'd1:    c = 4'd3;
                default: c = 4'd1;
            endcase
        end
        return c;
    endfunction

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [127:0] r_data;
    mode_t        r_mode;
    logic [3:0]   r_idx;
    logic [1:0]   r_beat;
    logic [7:0]   r_acc;
    logic [31:0]  w_col;
    logic [7:0]   w_prod [LANES];
    logic [7:0]   w_sum;
    logic         w_last_beat;
    logic         w_abort;

`ifdef AES128_MC_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    assign w_col       = r_data[{r_idx[3:2], 5'b00000} +: 32];
    assign w_last_beat = (r_beat == 2'(c_beats - 1));

    // Lane l of beat b handles input row k = b*LANES + l; coefficient index is (k - r) mod 4.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [1:0] w_k;
            logic [1:0] w_j;
            assign w_k       = 2'(int'(r_beat) * LANES + l);
            assign w_j       = w_k - r_idx[1:0];
            assign w_prod[l] = gf_mul_const(w_col[{w_k, 3'b000} +: 8], coef(r_mode, w_j));
        end
    endgenerate

    always_comb begin
        w_sum = 8'h00;
        for (int l = 0; l < LANES; l++) begin
            w_sum = w_sum ^ w_prod[l];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: if (start_i) w_state_nxt = c_calc;
            c_calc: begin
                if (w_abort)          w_state_nxt = c_idle;
                else if (w_last_beat) w_state_nxt = c_out;
            end
            c_out: begin
                if (w_abort)      w_state_nxt = c_idle;
                else if (ready_i) w_state_nxt = (r_idx == 4'd15) ? c_done : c_calc;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        data_o  = 8'h00;
        addr_o  = 4'h0;
        busy_o  = (r_state != c_idle);
        done_o  = (r_state == c_done);
        if (r_state == c_out) begin
            valid_o = 1'b1;
            data_o  = r_acc;
            addr_o  = r_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data <= '0;
            r_mode <= ENCRYPT;
            r_idx  <= 4'h0;
            r_beat <= 2'd0;
            r_acc  <= 8'h00;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start_i) begin
                        r_data <= data_i;
                        r_mode <= mode_i;
                        r_idx  <= 4'h0;
                        r_beat <= 2'd0;
                    end
                end
                c_calc: begin
                    r_acc  <= (r_beat == 2'd0) ? w_sum : (r_acc ^ w_sum);
                    r_beat <= w_last_beat ? 2'd0 : (r_beat + 2'd1);
                end
                c_out: begin
                    if (!w_abort && ready_i && (r_idx != 4'd15)) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes128_mix_columns_par.sv
`default_nettype none
// Bench for aes128_mix_columns_par: three instances (LANES=1,2,4) driven one at a
// time by directed steps; expected bytes go through a scoreboard queue.

module tb_aes128_mix_columns_par;
    import aes128_type_pkg::*;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start [3];
    mode_t        mode  [3];
    logic [127:0] din   [3];
    logic         rdy   [3];
    logic         valid [3];
    logic [7:0]   dout  [3];
    logic [3:0]   addr  [3];
    logic         busy  [3];
    logic         done  [3];
`ifdef AES128_MC_ABORT_EN
    logic         abort [3];
`endif

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            aes128_mix_columns_par #(.LANES(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
                .clk_i   (clk),
                .rst_n_i (rst_n),
                .start_i (start[g]),
                .mode_i  (mode[g]),
                .data_i  (din[g]),
                .ready_i (rdy[g]),
`ifdef AES128_MC_ABORT_EN
                .abort_i (abort[g]),
`endif
                .valid_o (valid[g]),
                .data_o  (dout[g]),
                .addr_o  (addr[g]),
                .busy_o  (busy[g]),
                .done_o  (done[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input bit dec, input logic [127:0] s);
        logic [7:0]   m [4];
        logic [127:0] o;
        logic [7:0]   acc;
        if (dec) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(s[c*32 + k*8 +: 8], m[(k - r + 4) % 4]);
                end
                o[c*32 + r*8 +: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic push_exp(input logic [127:0] e);
        for (int a = 0; a < 16; a++) begin
            sb.push_back('{addr: 4'(a), data: e[a*8 +: 8]});
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_valid"}, 32'(valid[d]), 0);
        check({tag, "_data"},  32'(dout[d]),  0);
        check({tag, "_addr"},  32'(addr[d]),  0);
        check({tag, "_busy"},  32'(busy[d]),  0);
        check({tag, "_done"},  32'(done[d]),  0);
    endtask

    // One full block on instance d; scoreboard must already hold the 16 expected bytes.
    task automatic run_block(input int d, input bit dec, input logic [127:0] data,
                             input int stall_addr, input int stall_len, input bit mutate);
        int         beats;
        int         t0;
        int         first_cyc;
        int         stalled;
        int         got;
        bit         fin;
        logic [7:0] hd;
        logic [3:0] ha;
        exp_t       e;
        beats     = (d == 0) ? 4 : ((d == 1) ? 2 : 1);
        first_cyc = -1;
        stalled   = 0;
        got       = 0;
        fin       = 1'b0;
        hd        = 8'h00;
        ha        = 4'h0;
        @(negedge clk);
        start[d] = 1'b1;
        mode[d]  = dec ? DECRYPT : ENCRYPT;
        din[d]   = data;
        rdy[d]   = 1'b1;
        t0       = cyc;
        @(negedge clk);
        check("busy_after_start", 32'(busy[d]), 1);
        if (mutate) begin
            mode[d] = dec ? ENCRYPT : DECRYPT;
            din[d]  = ~data;
        end else begin
            start[d] = 1'b0;
        end
        for (int n = 0; n < 2000 && !fin; n++) begin
            if (done[d]) begin
                check("done_cycle", 32'(cyc - t0), 32'(16 * (beats + 1) + 1 + stall_len));
                check("bytes_seen", 32'(got), 16);
                check("done_valid_low", 32'(valid[d]), 0);
                start[d] = 1'b0;
                fin = 1'b1;
            end else if (valid[d]) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check("first_valid_cycle", 32'(first_cyc - t0), 32'(beats + 1));
                end
                if (mutate && addr[d] == 4'd8) din[d] = {data[63:0], data[127:64]};
                if (int'(addr[d]) == stall_addr && stalled < stall_len) begin
                    if (stalled > 0) begin
                        check("stall_hold_data", 32'(dout[d]), 32'(hd));
                        check("stall_hold_addr", 32'(addr[d]), 32'(ha));
                    end
                    hd = dout[d];
                    ha = addr[d];
                    stalled++;
                    rdy[d] = 1'b0;
                end else begin
                    if (stall_len > 0 && stalled == stall_len && int'(addr[d]) == stall_addr) begin
                        check("stall_release_data", 32'(dout[d]), 32'(hd));
                    end
                    rdy[d] = 1'b1;
                    check("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("byte_addr", 32'(addr[d]), 32'(e.addr));
                        check("byte_data", 32'(dout[d]), 32'(e.data));
                    end
                    got++;
                end
            end
            if (!fin) @(negedge clk);
        end
        check("block_finished", 32'(fin), 1);
        rdy[d] = 1'b1;
        @(negedge clk);
        check("done_one_cycle", 32'(done[d]), 0);
        check("idle_after_done", 32'(busy[d]), 0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0;
            mode[d]  = ENCRYPT;
            din[d]   = '0;
            rdy[d]   = 1'b1;
`ifdef AES128_MC_ABORT_EN
            abort[d] = 1'b0;
`endif
        end
        #2;
        for (int d = 0; d < 3; d++) check_idle_outputs(d, "reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ENCRYPT, LANES=1, FIPS-style column db 13 53 45, others c6
        push_exp(128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_bca14d8e);
        run_block(0, 1'b0, 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_455313db, -1, 0, 1'b0);

        // DECRYPT, LANES=4
        push_exp(128'hc6c6c6c6_c6c6c6c6_5c220af2_455313db);
        run_block(2, 1'b1, 128'hc6c6c6c6_c6c6c6c6_9d58dc9f_bca14d8e, -1, 0, 1'b0);

        // ENCRYPT, LANES=2
        push_exp(128'h01010101_01010101_01010101_e5816604);
        run_block(1, 1'b0, 128'h01010101_01010101_01010101_305dbfd4, -1, 0, 1'b0);

        // Backpressure: 7 stall cycles on addr 5
        push_exp(mix_model(1'b0, 128'h00112233_44556677_8899aabb_ccddeeff));
        run_block(0, 1'b0, 128'h00112233_44556677_8899aabb_ccddeeff, 5, 7, 1'b0);

        // start held and inputs changed while busy must not disturb the run
        push_exp(mix_model(1'b1, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0));
        run_block(1, 1'b1, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, -1, 0, 1'b1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        start[0] = 1'b1;
        mode[0]  = ENCRYPT;
        din[0]   = 128'hdeadbeef_01234567_89abcdef_fedcba98;
        @(negedge clk);
        start[0] = 1'b0;
        @(posedge clk);
        #2;
        check("busy_before_reset", 32'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(mix_model(1'b1, 128'hdeadbeef_01234567_89abcdef_fedcba98));
        run_block(0, 1'b1, 128'hdeadbeef_01234567_89abcdef_fedcba98, -1, 0, 1'b0);

`ifdef AES128_MC_ABORT_EN
        begin
            bit seen;
            seen = 1'b0;
            @(negedge clk);
            start[2] = 1'b1;
            mode[2]  = ENCRYPT;
            din[2]   = 128'h13579bdf_2468ace0_0f0f0f0f_a5a5a5a5;
            rdy[2]   = 1'b1;
            @(negedge clk);
            start[2] = 1'b0;
            for (int n = 0; n < 200 && !seen; n++) begin
                if (valid[2] && addr[2] == 4'd9) seen = 1'b1;
                else @(negedge clk);
            end
            check("abort_reached_addr9", 32'(seen), 1);
            abort[2] = 1'b1;
            @(negedge clk);
            abort[2] = 1'b0;
            check("abort_valid", 32'(valid[2]), 0);
            check("abort_busy", 32'(busy[2]), 0);
            check("abort_done", 32'(done[2]), 0);
            @(negedge clk);
            check("abort_no_done_later", 32'(done[2]), 0);
            push_exp(mix_model(1'b0, 128'h13579bdf_2468ace0_0f0f0f0f_a5a5a5a5));
            run_block(2, 1'b0, 128'h13579bdf_2468ace0_0f0f0f0f_a5a5a5a5, -1, 0, 1'b0);
        end
`endif

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
